// File: rtl/axi_sram_slave.sv
// Single-beat AXI3 slave backed by a word-addressed SRAM, with one outstanding read
// and one outstanding write, each sequenced by its own FSM with programmable latency.
module axi_sram_slave #(
   parameter int MEM_AW = 12,
   parameter int R_LAT  = 1,
   parameter int B_LAT  = 1
) (
   input  logic        aclk,
   input  logic        reset,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [2:0]  arsize,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int         DEPTH   = 1 << MEM_AW;
   localparam logic [3:0] R_LAT_C = 4'(R_LAT);
   localparam logic [3:0] B_LAT_C = 4'(B_LAT);

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_CMT, W_WAIT, W_RESP} w_state_t;

   logic [31:0] mem [DEPTH];

   r_state_t          r_state;
   logic [3:0]        r_cnt;
   logic [3:0]        arid_q;
   logic [MEM_AW-1:0] ar_idx_q;
   logic [MEM_AW-1:0] rd_idx;

   w_state_t          w_state;
   logic [3:0]        b_cnt;
   logic [3:0]        awid_q;
   logic [MEM_AW-1:0] aw_idx_q;
   logic [31:0]       wdata_q;
   logic [3:0]        wstrb_q;
   logic              aw_held;
   logic              w_held;
   logic              aw_hs;
   logic              w_hs;

   // Size and the non-word address bits carry no meaning for a word-wide RAM.
   logic unused_bits;
   assign unused_bits = ^{arsize, araddr[31:MEM_AW+2], araddr[1:0],
                          awaddr[31:MEM_AW+2], awaddr[1:0]};

   assign rresp = 2'b00;
   assign bresp = 2'b00;
   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;

   // With zero read latency the word is fetched on the same edge as the ar handshake.
   assign rd_idx = (r_state == R_IDLE) ? araddr[MEM_AW+1:2] : ar_idx_q;

   // NOTE: all clocked state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge aclk) begin
      if (reset) begin
         r_state  <= R_IDLE;
         r_cnt    <= '0;
         arid_q   <= '0;
         ar_idx_q <= '0;
         arready  <= 1'b0;
         rvalid   <= 1'b0;
         rlast    <= 1'b0;
         rid      <= '0;
         rdata    <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (arvalid && arready) begin
                  arready  <= 1'b0;
                  arid_q   <= arid;
                  ar_idx_q <= araddr[MEM_AW+1:2];
                  r_cnt    <= R_LAT_C;
                  if (R_LAT_C == 4'd0) begin
                     r_state <= R_RESP;
                     rvalid  <= 1'b1;
                     rlast   <= 1'b1;
                     rid     <= arid;
                     rdata   <= mem[rd_idx];
                  end else begin
                     r_state <= R_WAIT;
                  end
               end else begin
                  arready <= 1'b1;
               end
            end
            R_WAIT: begin
               if (r_cnt == 4'd1) begin
                  r_state <= R_RESP;
                  rvalid  <= 1'b1;
                  rlast   <= 1'b1;
                  rid     <= arid_q;
                  rdata   <= mem[rd_idx];
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            R_RESP: begin
               // arready stays low for the cycle after the r handshake.
               if (rready) begin
                  r_state <= R_IDLE;
                  rvalid  <= 1'b0;
                  rlast   <= 1'b0;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         w_state  <= W_IDLE;
         b_cnt    <= '0;
         awid_q   <= '0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         awready  <= 1'b0;
         wready   <= 1'b0;
         bvalid   <= 1'b0;
         bid      <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  awid_q   <= awid;
                  aw_idx_q <= awaddr[MEM_AW+1:2];
                  aw_held  <= 1'b1;
                  awready  <= 1'b0;
               end else begin
                  awready <= !aw_held;
               end
               if (w_hs) begin
                  wdata_q <= wdata;
                  wstrb_q <= wstrb;
                  w_held  <= 1'b1;
                  wready  <= 1'b0;
               end else begin
                  wready <= !w_held;
               end
               if ((aw_held || aw_hs) && (w_held || w_hs))
                  w_state <= W_CMT;
            end
            W_CMT: begin
               b_cnt <= B_LAT_C;
               if (B_LAT_C == 4'd0) begin
                  w_state <= W_RESP;
                  bvalid  <= 1'b1;
                  bid     <= awid_q;
               end else begin
                  w_state <= W_WAIT;
               end
            end
            W_WAIT: begin
               if (b_cnt == 4'd1) begin
                  w_state <= W_RESP;
                  bvalid  <= 1'b1;
                  bid     <= awid_q;
               end else begin
                  b_cnt <= b_cnt - 4'd1;
               end
            end
            W_RESP: begin
               if (bready) begin
                  w_state <= W_IDLE;
                  bvalid  <= 1'b0;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  awready <= 1'b1;
                  wready  <= 1'b1;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // NOTE: the memory array is deliberately not reset; clearing every word is not
   // something a RAM macro can do and contents are defined only by writes.
   always_ff @(posedge aclk) begin
      if (!reset && w_state == W_CMT) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i])
               mem[aw_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised self-checking bench for axi_sram_slave against a word-array reference model.
module tb_axi_sram_slave;

   localparam int MEM_AW = 6;
   localparam int R_LAT  = 2;
   localparam int B_LAT  = 1;
   localparam int DEPTH  = 1 << MEM_AW;

   logic        aclk;
   logic        reset;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [31:0] model_mem [DEPTH];

   axi_sram_slave #(.MEM_AW(MEM_AW), .R_LAT(R_LAT), .B_LAT(B_LAT)) dut (
      .aclk(aclk), .reset(reset),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Byte-lane merge: each set strobe bit replaces one byte of the stored word.
   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++)
         if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   function automatic int word_of(input logic [31:0] addr);
      return int'(addr[MEM_AW+1:2]);
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      model_mem[word_of(addr)] = merge(model_mem[word_of(addr)], data, strb);
   endtask

   // One read: waits for arready, handshakes, counts cycles to rvalid, then accepts it.
   task automatic read_txn(input logic [31:0] addr, input logic [3:0] id,
                           output logic [31:0] data, output logic [3:0] rid_o,
                           output logic rlast_o, output logic [1:0] rresp_o,
                           output int lat, output bit tmo);
      int n;
      n   = 0;
      tmo = 0;
      while (!arready && n < 20) begin @(negedge aclk); n++; end
      if (n >= 20) tmo = 1;
      arvalid = 1'b1; araddr = addr; arid = id; arsize = 3'($urandom);
      @(negedge aclk);
      arvalid = 1'b0;
      lat = 1;
      while (!rvalid && lat < 40) begin @(negedge aclk); lat++; end
      if (lat >= 40) tmo = 1;
      data = rdata; rid_o = rid; rlast_o = rlast; rresp_o = rresp;
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
   endtask

   // One write: w handshake at offset tw, aw at offset taw; latency counted from the later one.
   task automatic write_txn(input logic [31:0] addr, input logic [3:0] id,
                            input logic [31:0] data, input logic [3:0] strb,
                            input int tw, input int taw, input bit tie_bready,
                            output int blat, output logic [3:0] bid_o, output logic [1:0] bresp_o,
                            output logic awr_after, output logic wr_after,
                            output int bcycles, output bit tmo);
      int n;
      int last;
      n   = 0;
      tmo = 0;
      while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
      if (n >= 20) tmo = 1;
      if (tie_bready) bready = 1'b1;
      last = (tw > taw) ? tw : taw;
      awaddr = addr; awid = id; wdata = data; wstrb = strb;
      for (int c = 0; c <= last; c++) begin
         awvalid = (c == taw);
         wvalid  = (c == tw);
         @(negedge aclk);
      end
      awvalid = 1'b0; wvalid = 1'b0;
      awr_after = awready; wr_after = wready;
      blat = 1;
      while (!bvalid && blat < 40) begin @(negedge aclk); blat++; end
      if (blat >= 40) tmo = 1;
      bid_o = bid; bresp_o = bresp;
      bready  = 1'b1;
      bcycles = 0;
      while (bvalid && bcycles < 10) begin bcycles++; @(negedge aclk); end
      bready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge aclk);
      chk_cnt++;
      if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000", {arready, awready, wready, rvalid, bvalid, rlast});
      else pass_cnt++;
      chk_cnt++;
      if ({rid, bid, rdata, rresp, bresp} !== 44'h0)
         $display("FAIL reset_data: got %h want 0", {rid, bid, rdata, rresp, bresp});
      else pass_cnt++;
      reset = 1'b0;
      @(negedge aclk);
      chk_cnt++;
      if ({arready, awready, wready} !== 3'b111)
         $display("FAIL reset_release_readies: got %b want 111", {arready, awready, wready});
      else pass_cnt++;
      chk_cnt++;
      if ({rvalid, bvalid} !== 2'b00)
         $display("FAIL reset_release_valids: got %b want 00", {rvalid, bvalid});
      else pass_cnt++;
   endtask

   task automatic test_read_basic;
      logic [31:0] d; logic [3:0] i; logic l; logic [1:0] rs; int lat; bit tmo;
      logic a_r, w_r; int bc;
      write_txn(32'h10, 4'd2, 32'h11223344, 4'hF, 0, 0, 1'b0, lat, i, rs, a_r, w_r, bc, tmo);
      model_write(32'h10, 32'h11223344, 4'hF);
      chk_cnt++;
      if (lat !== 2 + B_LAT) $display("FAIL t1_write_latency: got %0d want %0d", lat, 2 + B_LAT);
      else pass_cnt++;
      read_txn(32'h10, 4'd0, d, i, l, rs, lat, tmo);
      chk_cnt++;
      if (tmo !== 1'b0) $display("FAIL t1_timeout: got %0d want 0", tmo); else pass_cnt++;
      chk_cnt++;
      if (lat !== 1 + R_LAT) $display("FAIL t1_read_latency: got %0d want %0d", lat, 1 + R_LAT);
      else pass_cnt++;
      chk_cnt++;
      if (d !== 32'h11223344) $display("FAIL t1_rdata: got %h want 11223344", d); else pass_cnt++;
      chk_cnt++;
      if ({i, l, rs} !== 7'b0000_1_00) $display("FAIL t1_rid_rlast_rresp: got %b want 0000100", {i, l, rs});
      else pass_cnt++;
   endtask

   task automatic test_w_before_aw;
      logic [31:0] d; logic [3:0] i; logic l; logic [1:0] rs; int lat; bit tmo;
      logic a_r, w_r; int bc;
      write_txn(32'h20, 4'd0, 32'h0, 4'hF, 0, 0, 1'b0, lat, i, rs, a_r, w_r, bc, tmo);
      model_write(32'h20, 32'h0, 4'hF);
      write_txn(32'h20, 4'd1, 32'hAABBCCDD, 4'b0011, 0, 2, 1'b0, lat, i, rs, a_r, w_r, bc, tmo);
      model_write(32'h20, 32'hAABBCCDD, 4'b0011);
      chk_cnt++;
      if (lat !== 2 + B_LAT) $display("FAIL t2_b_latency: got %0d want %0d", lat, 2 + B_LAT);
      else pass_cnt++;
      chk_cnt++;
      if (i !== 4'd1) $display("FAIL t2_bid: got %0d want 1", i); else pass_cnt++;
      chk_cnt++;
      if (rs !== 2'b00) $display("FAIL t2_bresp: got %b want 00", rs); else pass_cnt++;
      read_txn(32'h20, 4'd9, d, i, l, rs, lat, tmo);
      chk_cnt++;
      if (d !== model_mem[8]) $display("FAIL t2_readback: got %h want %h", d, model_mem[8]);
      else pass_cnt++;
   endtask

   task automatic test_backpressure;
      int n; int extra;
      n = 0;
      while (!arready && n < 20) begin @(negedge aclk); n++; end
      arvalid = 1'b1; araddr = 32'hFFFF_FF10; arid = 4'd5;
      @(negedge aclk);
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 40) begin @(negedge aclk); n++; end
      for (int k = 0; k < 5; k++) begin
         chk_cnt++;
         if ({rvalid, rlast, rid, arready} !== {1'b1, 1'b1, 4'd5, 1'b0})
            $display("FAIL t3_hold_ctrl[%0d]: got %b want 11010 1 0", k, {rvalid, rlast, rid, arready});
         else pass_cnt++;
         chk_cnt++;
         if (rdata !== model_mem[4]) $display("FAIL t3_hold_data[%0d]: got %h want %h", k, rdata, model_mem[4]);
         else pass_cnt++;
         @(negedge aclk);
      end
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      extra = 0;
      repeat (8) begin
         if (rvalid) extra++;
         @(negedge aclk);
      end
      chk_cnt++;
      if (extra !== 0) $display("FAIL t3_single_response: got %0d extra rvalid cycles want 0", extra);
      else pass_cnt++;
   endtask

   task automatic test_same_cycle;
      logic [31:0] d, v; logic [3:0] i; logic l; logic [1:0] rs; int lat; bit tmo;
      logic a_r, w_r; int bc;
      v = $urandom;
      write_txn(32'h30, 4'd6, v, 4'hF, 0, 0, 1'b1, lat, i, rs, a_r, w_r, bc, tmo);
      model_write(32'h30, v, 4'hF);
      chk_cnt++;
      if ({a_r, w_r} !== 2'b00) $display("FAIL t4_readies_after: got %b want 00", {a_r, w_r});
      else pass_cnt++;
      chk_cnt++;
      if (bc !== 1) $display("FAIL t4_bvalid_pulse: got %0d cycles want 1", bc); else pass_cnt++;
      chk_cnt++;
      if (lat !== 2 + B_LAT) $display("FAIL t4_b_latency: got %0d want %0d", lat, 2 + B_LAT);
      else pass_cnt++;
      chk_cnt++;
      if (i !== 4'd6) $display("FAIL t4_bid: got %0d want 6", i); else pass_cnt++;
      read_txn(32'h30, 4'd3, d, i, l, rs, lat, tmo);
      chk_cnt++;
      if (d !== v) $display("FAIL t4_readback: got %h want %h", d, v); else pass_cnt++;
   endtask

   task automatic test_random;
      logic [31:0] d, a, v; logic [3:0] i, id, s; logic l; logic [1:0] rs; int lat; bit tmo;
      logic a_r, w_r; int bc; int tw, taw;
      for (int k = 0; k < DEPTH; k++) begin
         v = $urandom;
         write_txn(32'(k * 4), 4'd0, v, 4'hF, 0, 0, 1'b0, lat, i, rs, a_r, w_r, bc, tmo);
         model_write(32'(k * 4), v, 4'hF);
      end
      for (int k = 0; k < 80; k++) begin
         a  = $urandom;
         id = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 0) begin
            v   = $urandom;
            s   = 4'($urandom_range(0, 15));
            tw  = $urandom_range(0, 2);
            taw = $urandom_range(0, 2);
            write_txn(a, id, v, s, tw, taw, 1'($urandom_range(0, 1)), lat, i, rs, a_r, w_r, bc, tmo);
            model_write(a, v, s);
            chk_cnt++;
            if ({tmo, lat, i, rs, bc} !== {1'b0, 2 + B_LAT, id, 2'b00, 1})
               $display("FAIL rnd_write[%0d]: got tmo=%0d lat=%0d bid=%0d bresp=%0d pulse=%0d want 0 %0d %0d 0 1",
                        k, tmo, lat, i, rs, bc, 2 + B_LAT, id);
            else pass_cnt++;
         end else begin
            read_txn(a, id, d, i, l, rs, lat, tmo);
            chk_cnt++;
            if (d !== model_mem[word_of(a)])
               $display("FAIL rnd_rdata[%0d]: addr %h got %h want %h", k, a, d, model_mem[word_of(a)]);
            else pass_cnt++;
            chk_cnt++;
            if ({tmo, lat, i, l, rs} !== {1'b0, 1 + R_LAT, id, 1'b1, 2'b00})
               $display("FAIL rnd_rctl[%0d]: got tmo=%0d lat=%0d rid=%0d rlast=%0d rresp=%0d want 0 %0d %0d 1 0",
                        k, tmo, lat, i, l, rs, 1 + R_LAT, id);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d, exp_word; logic [3:0] i; logic l; logic [1:0] rs; int lat; bit tmo;
      int n; int hits;
      exp_word = model_mem[17];
      n = 0;
      while (!(arready && awready && wready) && n < 20) begin @(negedge aclk); n++; end
      arvalid = 1'b1; araddr = 32'h44; arid = 4'd3;
      @(negedge aclk);
      arvalid = 1'b0;
      chk_cnt++;
      if (rvalid !== 1'b0) $display("FAIL t5_in_wait: got rvalid %b want 0", rvalid); else pass_cnt++;
      awvalid = 1'b1; awaddr = 32'h44; awid = 4'd7;
      @(negedge aclk);
      awvalid = 1'b0;
      chk_cnt++;
      if ({awready, wready} !== 2'b01) $display("FAIL t5_aw_held: got %b want 01", {awready, wready});
      else pass_cnt++;
      reset = 1'b1;
      repeat (2) @(negedge aclk);
      chk_cnt++;
      if ({arready, awready, wready, rvalid, bvalid} !== 5'b0)
         $display("FAIL t5_in_reset: got %b want 00000", {arready, awready, wready, rvalid, bvalid});
      else pass_cnt++;
      reset = 1'b0;
      @(negedge aclk);
      chk_cnt++;
      if ({arready, awready, wready} !== 3'b111)
         $display("FAIL t5_readies_after: got %b want 111", {arready, awready, wready});
      else pass_cnt++;
      // A lone w half must not pair with the aw half that reset discarded.
      wvalid = 1'b1; wdata = ~exp_word; wstrb = 4'hF;
      @(negedge aclk);
      wvalid = 1'b0;
      hits = 0;
      repeat (10) begin
         if (rvalid || bvalid) hits++;
         @(negedge aclk);
      end
      chk_cnt++;
      if (hits !== 0) $display("FAIL t5_no_response: got %0d valid cycles want 0", hits); else pass_cnt++;
      read_txn(32'h44, 4'd2, d, i, l, rs, lat, tmo);
      chk_cnt++;
      if (d !== exp_word) $display("FAIL t5_mem_unchanged: got %h want %h", d, exp_word); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1;
      arid = '0; araddr = '0; arsize = '0; arvalid = 1'b0; rready = 1'b0;
      awid = '0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      @(negedge aclk);
      test_reset();
      test_read_basic();
      test_w_before_aw();
      test_backpressure();
      test_same_cycle();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
